rf_sequencer: RTL and testbench

Multi-cycle micro-sequencer that executes simple register-to-register instructions on the 8x8 register file. It accepts one instruction at a time over a valid/ready handshake and drives the file's read ports (RX/RY), captures the operands, and computes an 8-bit ALU result. It then writes the result back through the write port (RW/WEN/busW). It sits between an instruction source (testbench or fetch unit) and the register file instance, and it is the register file's only driver.

---
 rtl/rf_pkg.sv | 32 +++
 rtl/rf_sequencer_if.sv | 23 ++
 rtl/register_file.sv | 38 +++
 rtl/rf_alu.sv | 42 ++++
 rtl/rf_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rf_sequencer.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file micro-sequencer: opcodes, FSM
// state encoding and default widths.
package rf_pkg;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_LI  = 3'd6,
        OP_NOP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Ops that need both register operands fetched before execution.
    function automatic logic is_alu_op(input opcode_t op);
        return (op != OP_LI) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/rf_sequencer_if.sv
// Instruction handshake between an instruction source and the sequencer.
interface rf_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 3
) ();
    logic          inst_valid;
    logic          inst_ready;
    logic [2:0]    inst_op;
    logic [AW-1:0] inst_rd;
    logic [AW-1:0] inst_rs;
    logic [AW-1:0] inst_rt;
    logic [DW-1:0] inst_imm;

    modport master (
        output inst_valid, inst_op, inst_rd, inst_rs, inst_rt, inst_imm,
        input  inst_ready
    );

    modport slave (
        input  inst_valid, inst_op, inst_rd, inst_rs, inst_rt, inst_imm,
        output inst_ready
    );
endinterface

// File: rtl/register_file.sv
// 2^AW x DW register file, two combinational read ports, one write port;
// register 0 always reads as zero.
module register_file #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          WEN,
    input  logic [AW-1:0] RW,
    input  logic [DW-1:0] busW,
    input  logic [AW-1:0] RX,
    input  logic [AW-1:0] RY,
    output logic [DW-1:0] busX,
    output logic [DW-1:0] busY
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [DEPTH];

    // Storage array; writes to address 0 are discarded.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (WEN && (RW != '0)) begin
            mem_r[RW] <= busW;
        end else begin
            mem_r[RW] <= mem_r[RW];
        end
    end

    assign busX = (RX == '0) ? '0 : mem_r[RX];
    assign busY = (RY == '0) ? '0 : mem_r[RY];

endmodule

// File: rtl/rf_alu.sv
// Combinational ALU: 9-bit add/subtract with carry/borrow, logic ops and
// a 3-bit left shift.
module rf_alu
    import rf_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  opcode_t       op,
    input  logic [DW-1:0] op_x,
    input  logic [DW-1:0] op_y,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [DW:0] sum_s;

    // Result and carry selection; carry is only meaningful for ADD/SUB.
    always_comb begin
        sum_s  = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sum_s  = {1'b0, op_x} + {1'b0, op_y};
                result = sum_s[DW-1:0];
                carry  = sum_s[DW];
            end
            OP_SUB: begin
                // Bit DW of the wrapped difference is the borrow.
                sum_s  = {1'b0, op_x} - {1'b0, op_y};
                result = sum_s[DW-1:0];
                carry  = sum_s[DW];
            end
            OP_AND:  result = op_x & op_y;
            OP_OR:   result = op_x | op_y;
            OP_XOR:  result = op_x ^ op_y;
            OP_SHL:  result = op_x << op_y[2:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle micro-sequencer: accepts one instruction, reads operands from
// the register file, executes on rf_alu and writes the result back.
module rf_sequencer
    import rf_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    rf_sequencer_if.slave    inst,
    output logic             rf_WEN,
    output logic [AW-1:0]    rf_RW,
    output logic [DW-1:0]    rf_busW,
    output logic [AW-1:0]    rf_RX,
    output logic [AW-1:0]    rf_RY,
    input  logic [DW-1:0]    rf_busX,
    input  logic [DW-1:0]    rf_busY,
    output logic             done,
    output logic [DW-1:0]    result,
    output logic             carry,
    output logic [CNT_W-1:0] inst_cnt
);

    state_t            state_r;
    state_t            next_state_s;
    opcode_t           in_op_s;
    opcode_t           op_r;
    logic [AW-1:0]     rd_r;
    logic [AW-1:0]     wr_rd_s;
    logic              accept_s;
    logic              retire_s;
    logic              ready_r;
    logic [AW-1:0]     rx_r;
    logic [AW-1:0]     ry_r;
    logic [AW-1:0]     rw_r;
    logic              wen_r;
    logic [DW-1:0]     opx_r;
    logic [DW-1:0]     opy_r;
    logic [DW-1:0]     result_r;
    logic              carry_r;
    logic              done_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DW-1:0]     alu_result_s;
    logic              alu_carry_s;

    assign in_op_s  = opcode_t'(inst.inst_op);
    assign accept_s = (state_r == S_IDLE) && inst.inst_valid;
    assign retire_s = (state_r == S_WRITE) || (accept_s && (in_op_s == OP_NOP));
    // LI goes straight from IDLE to WRITE, so its rd comes from the bus.
    assign wr_rd_s  = (state_r == S_IDLE) ? inst.inst_rd : rd_r;

    rf_alu #(.DW(DW)) u_alu (
        .op     (op_r),
        .op_x   (opx_r),
        .op_y   (opy_r),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (in_op_s == OP_NOP) begin
                        next_state_s = S_IDLE;
                    end else if (in_op_s == OP_LI) begin
                        next_state_s = S_WRITE;
                    end else if (is_alu_op(in_op_s)) begin
                        next_state_s = S_READ;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_READ:  next_state_s = S_EXEC;
            S_EXEC:  next_state_s = S_WRITE;
            S_WRITE: next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Port-facing registers, loaded from the state being entered so they are
    // valid for the whole of that state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ready_r <= 1'b1;
            rx_r    <= '0;
            ry_r    <= '0;
            rw_r    <= '0;
            wen_r   <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            ready_r <= (next_state_s == S_IDLE);
            rx_r    <= (next_state_s == S_READ)  ? inst.inst_rs : '0;
            ry_r    <= (next_state_s == S_READ)  ? inst.inst_rt : '0;
            rw_r    <= (next_state_s == S_WRITE) ? wr_rd_s      : '0;
            wen_r   <= (next_state_s == S_WRITE) && (wr_rd_s != '0);
            done_r  <= retire_s;
            if (retire_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Instruction fields, operands and the held result/carry.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_r     <= OP_ADD;
            rd_r     <= '0;
            opx_r    <= '0;
            opy_r    <= '0;
            result_r <= '0;
            carry_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r <= in_op_s;
                rd_r <= inst.inst_rd;
            end else begin
                op_r <= op_r;
                rd_r <= rd_r;
            end
            if (state_r == S_READ) begin
                opx_r <= rf_busX;
                opy_r <= rf_busY;
            end else begin
                opx_r <= opx_r;
                opy_r <= opy_r;
            end
            if (state_r == S_EXEC) begin
                result_r <= alu_result_s;
                carry_r  <= alu_carry_s;
            end else if (accept_s && (in_op_s == OP_LI)) begin
                result_r <= inst.inst_imm;
                carry_r  <= carry_r;
            end else begin
                result_r <= result_r;
                carry_r  <= carry_r;
            end
        end
    end

    assign inst.inst_ready = ready_r;
    assign rf_WEN          = wen_r;
    assign rf_RW           = rw_r;
    assign rf_busW         = result_r;
    assign rf_RX           = rx_r;
    assign rf_RY           = ry_r;
    assign done            = done_r;
    assign result          = result_r;
    assign carry           = carry_r;
    assign inst_cnt        = cnt_r;

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed self-checking bench for rf_sequencer driving a register_file.
module tb_rf_sequencer;

    logic        Clk;
    logic        Rst_n;
    logic        rf_WEN;
    logic [2:0]  rf_RW;
    logic [7:0]  rf_busW;
    logic [2:0]  rf_RX;
    logic [2:0]  rf_RY;
    logic [7:0]  rf_busX;
    logic [7:0]  rf_busY;
    logic        done;
    logic [7:0]  result;
    logic        carry;
    logic [15:0] inst_cnt;

    rf_sequencer_if #(.DW(8), .AW(3)) bus ();

    rf_sequencer #(.DW(8), .AW(3), .CNT_W(16)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .inst     (bus.slave),
        .rf_WEN   (rf_WEN),
        .rf_RW    (rf_RW),
        .rf_busW  (rf_busW),
        .rf_RX    (rf_RX),
        .rf_RY    (rf_RY),
        .rf_busX  (rf_busX),
        .rf_busY  (rf_busY),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .inst_cnt (inst_cnt)
    );

    register_file #(.DW(8), .AW(3)) u_rf (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .WEN   (rf_WEN),
        .RW    (rf_RW),
        .busW  (rf_busW),
        .RX    (rf_RX),
        .RY    (rf_RY),
        .busX  (rf_busX),
        .busY  (rf_busY)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wr_n   = 0;
    int done_n = 0;
    logic [2:0] log_rw   [64];
    logic [7:0] log_w    [64];
    int         log_edge [64];

    // Write log: every edge where rf_WEN is high is a landed write.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (rf_WEN && (wr_n < 64)) begin
            log_rw[wr_n]   <= rf_RW;
            log_w[wr_n]    <= rf_busW;
            log_edge[wr_n] <= cyc + 1;
            wr_n           <= wr_n + 1;
        end
    end

    always @(negedge Clk) begin
        if (done) done_n <= done_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction and return the edge count at which it was taken.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] imm, input bit keep,
                         output int acc_edge);
        bit ok = 1'b0;
        acc_edge = -100;
        @(negedge Clk);
        bus.inst_op    = op;
        bus.inst_rd    = rd;
        bus.inst_rs    = rs;
        bus.inst_rt    = rt;
        bus.inst_imm   = imm;
        bus.inst_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                if (bus.inst_ready) begin
                    @(posedge Clk);
                    #1;
                    ok = 1'b1;
                    acc_edge = cyc;
                end else begin
                    @(negedge Clk);
                end
            end
        end
        if (!keep) bus.inst_valid = 1'b0;
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                @(negedge Clk);
                if (done) seen = 1'b1;
            end
        end
        #1;
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    int acc;
    int n0;
    int accs [4];
    logic [2:0] b_op  [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    logic [2:0] b_rd  [4] = '{3'd3, 3'd4, 3'd5, 3'd6};
    logic [7:0] b_exp [4] = '{8'h01, 8'h07, 8'h06, 8'h28};

    initial begin
        Rst_n          = 1'b0;
        bus.inst_valid = 1'b0;
        bus.inst_op    = 3'd0;
        bus.inst_rd    = 3'd0;
        bus.inst_rs    = 3'd0;
        bus.inst_rt    = 3'd0;
        bus.inst_imm   = 8'd0;
        repeat (3) @(negedge Clk);
        check_eq("rst_ready", {31'd0, bus.inst_ready}, 32'd1);
        check_eq("rst_wen", {31'd0, rf_WEN}, 32'd0);
        check_eq("rst_cnt", {16'd0, inst_cnt}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", {24'd0, result}, 32'd0);
        Rst_n = 1'b1;

        // LI r1=5, LI r2=3
        issue(3'd6, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0, acc);
        wait_done();
        check_eq("li1_rw", {29'd0, log_rw[wr_n-1]}, 32'd1);
        check_eq("li1_w", {24'd0, log_w[wr_n-1]}, 32'h05);
        check_eq("li1_lat", log_edge[wr_n-1] - acc, 32'd1);
        issue(3'd6, 3'd2, 3'd0, 3'd0, 8'h03, 1'b0, acc);
        wait_done();
        check_eq("li2_rw", {29'd0, log_rw[wr_n-1]}, 32'd2);
        check_eq("li2_w", {24'd0, log_w[wr_n-1]}, 32'h03);
        check_eq("li_cnt", {16'd0, inst_cnt}, 32'd2);
        check_eq("li_done", done_n, 32'd2);
        check_eq("li_writes", wr_n, 32'd2);

        // ADD r3 = r1 + r2
        issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, acc);
        wait_done();
        check_eq("add_rw", {29'd0, log_rw[wr_n-1]}, 32'd3);
        check_eq("add_w", {24'd0, log_w[wr_n-1]}, 32'h08);
        check_eq("add_carry", {31'd0, carry}, 32'd0);
        check_eq("add_lat", log_edge[wr_n-1] - acc, 32'd3);
        check_eq("add_result", {24'd0, result}, 32'h08);

        // LI r4=FF; ADD r5 = r4 + r2 overflows; SUB r6 = r2 - r1 borrows
        issue(3'd6, 3'd4, 3'd0, 3'd0, 8'hFF, 1'b0, acc);
        wait_done();
        issue(3'd0, 3'd5, 3'd4, 3'd2, 8'h00, 1'b0, acc);
        wait_done();
        check_eq("addc_w", {24'd0, log_w[wr_n-1]}, 32'h02);
        check_eq("addc_carry", {31'd0, carry}, 32'd1);
        issue(3'd1, 3'd6, 3'd2, 3'd1, 8'h00, 1'b0, acc);
        wait_done();
        check_eq("sub_rw", {29'd0, log_rw[wr_n-1]}, 32'd6);
        check_eq("sub_w", {24'd0, log_w[wr_n-1]}, 32'hFE);
        check_eq("sub_borrow", {31'd0, carry}, 32'd1);

        // Writes to r0 are suppressed but still retire
        n0 = wr_n;
        issue(3'd6, 3'd0, 3'd0, 3'd0, 8'h55, 1'b0, acc);
        wait_done();
        check_eq("r0_nowrite", wr_n, n0);
        issue(3'd0, 3'd7, 3'd0, 3'd0, 8'h00, 1'b0, acc);
        wait_done();
        check_eq("r0add_rw", {29'd0, log_rw[wr_n-1]}, 32'd7);
        check_eq("r0add_w", {24'd0, log_w[wr_n-1]}, 32'h00);
        check_eq("r0add_carry", {31'd0, carry}, 32'd0);
        check_eq("r0_cnt", {16'd0, inst_cnt}, 32'd8);

        // Back-to-back ALU ops with inst_valid held high
        n0 = wr_n;
        for (int k = 0; k < 4; k++) begin
            issue(b_op[k], b_rd[k], 3'd1, 3'd2, 8'h00, 1'b1, accs[k]);
        end
        bus.inst_valid = 1'b0;
        repeat (6) @(negedge Clk);
        check_eq("b2b_writes", wr_n - n0, 32'd4);
        for (int k = 1; k < 4; k++) begin
            check_eq("b2b_spacing", accs[k] - accs[k-1], 32'd4);
        end
        for (int k = 0; k < 4; k++) begin
            check_eq("b2b_rw", {29'd0, log_rw[n0+k]}, {29'd0, b_rd[k]});
            check_eq("b2b_w", {24'd0, log_w[n0+k]}, {24'd0, b_exp[k]});
        end
        check_eq("b2b_span", log_edge[n0+3] - accs[0], 32'd15);
        check_eq("b2b_cnt", {16'd0, inst_cnt}, 32'd12);

        // NOP retires immediately without writing
        n0 = wr_n;
        issue(3'd7, 3'd3, 3'd0, 3'd0, 8'h00, 1'b0, acc);
        wait_done();
        check_eq("nop_cnt", {16'd0, inst_cnt}, 32'd13);
        check_eq("nop_nowrite", wr_n, n0);

        // Reset during EXEC of ADD r3 aborts it
        n0 = wr_n;
        issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, acc);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check_eq("abort_ready", {31'd0, bus.inst_ready}, 32'd1);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_cnt", {16'd0, inst_cnt}, 32'd0);
        check_eq("abort_wen", {31'd0, rf_WEN}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
        check_eq("abort_nowrite", wr_n, n0);

        // Sequencer works normally after the abort
        issue(3'd6, 3'd1, 3'd0, 3'd0, 8'h5A, 1'b0, acc);
        wait_done();
        check_eq("post_w", {24'd0, log_w[wr_n-1]}, 32'h5A);
        check_eq("post_cnt", {16'd0, inst_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
